// File: rtl/frame_check_sched_pkg.sv
// Shared definitions for the frame_check_sched block.
//   - state_e       : scheduler FSM states
//   - DEF_FRAME_LEN : default frame length in bits
//   - DEF_PATTERN   : default expected frame (first received bit = MSB)
//   - idx_width()   : index width helper, never narrower than 1 bit
package frame_check_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int DEF_FRAME_LEN = 6;
  localparam logic [DEF_FRAME_LEN-1:0] DEF_PATTERN = 6'b011100;

  // Width needed to index n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_check_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first requesting lane at or after ptr, wrapping modulo N_LANES.
// Ports:
//   req   : per-lane request vector
//   ptr   : lane with highest priority this round (always < N_LANES)
//   gnt   : one-hot grant of the selected lane (all zero when no request)
//   idx   : binary index of the selected lane
//   valid : at least one lane is requesting
module frame_check_sched_rr_arbiter
  import frame_check_sched_pkg::*;
#(
  parameter int N_LANES = 4,
  localparam int LANE_W = idx_width(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [LANE_W-1:0]  ptr,
  output logic [N_LANES-1:0] gnt,
  output logic [LANE_W-1:0]  idx,
  output logic               valid
);

  // Scan lanes starting at ptr; the first hit wins.
  always_comb begin : scan
    logic [LANE_W:0]   sum_s;
    logic [LANE_W-1:0] cand_s;
    logic              found_s;
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      // ptr + i can exceed N_LANES-1 by at most N_LANES-1, so one subtract wraps it.
      sum_s = {1'b0, ptr} + (LANE_W+1)'(i);
      if (sum_s >= (LANE_W+1)'(N_LANES)) begin
        sum_s = sum_s - (LANE_W+1)'(N_LANES);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[LANE_W-1:0];
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    valid = found_s;
  end

endmodule

// File: rtl/frame_check_sched.sv
// Shared serial frame checker with round-robin lane scheduling.
// One lane at a time is granted for exactly FRAME_LEN cycles; its serial bits
// are shifted in MSB-first, compared against PATTERN, and the outcome is
// reported for one cycle. Per-lane saturating counters track matches.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   req          : per-lane frame request level
//   data         : per-lane serial bit, only the granted lane is sampled
//   gnt          : one-hot grant, high during the FRAME_LEN sampling cycles
//   busy         : high while a frame is being shifted or reported
//   result_valid : one-cycle pulse per completed frame
//   result_match : frame equals PATTERN (qualified by result_valid)
//   result_lane  : lane of the reported frame
//   clr_cnt      : clear all match counters (wins over a same-cycle increment)
//   rd_sel       : counter read select
//   rd_cnt       : registered match count of lane rd_sel (0 when out of range)
module frame_check_sched
  import frame_check_sched_pkg::*;
#(
  parameter int                   N_LANES   = 4,
  parameter int                   FRAME_LEN = DEF_FRAME_LEN,
  parameter logic [FRAME_LEN-1:0] PATTERN   = DEF_PATTERN,
  parameter int                   CNT_W     = 8,
  localparam int                  LANE_W    = idx_width(N_LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] req,
  input  logic [N_LANES-1:0] data,
  output logic [N_LANES-1:0] gnt,
  output logic               busy,
  output logic               result_valid,
  output logic               result_match,
  output logic [LANE_W-1:0]  result_lane,
  input  logic               clr_cnt,
  input  logic [LANE_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]   rd_cnt
);

  localparam int BIT_W = idx_width(FRAME_LEN);

  state_e                 state_r;
  state_e                 next_state_s;
  logic [LANE_W-1:0]      lane_r;
  logic [LANE_W-1:0]      ptr_r;
  logic [BIT_W-1:0]       bit_cnt_r;
  logic [FRAME_LEN-1:0]   frame_r;
  logic [FRAME_LEN-1:0]   frame_next_s;
  logic                   last_bit_s;
  logic [CNT_W-1:0]       cnt_r [N_LANES];

  logic [N_LANES-1:0]     arb_gnt_s;
  logic [LANE_W-1:0]      arb_idx_s;
  logic                   arb_valid_s;

  logic [N_LANES-1:0]     gnt_s;
  logic                   busy_s;
  logic                   result_valid_s;
  logic                   result_match_s;
  logic [LANE_W-1:0]      result_lane_s;
  logic                   rd_in_range_s;

  frame_check_sched_rr_arbiter #(
    .N_LANES (N_LANES)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Frame contents including the bit being sampled this cycle.
  assign frame_next_s  = {frame_r[FRAME_LEN-2:0], data[lane_r]};
  assign last_bit_s    = (bit_cnt_r == BIT_W'(FRAME_LEN - 1));
  assign rd_in_range_s = ({1'b0, rd_sel} < (LANE_W+1)'(N_LANES));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; req is only looked at while idle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          next_state_s = ST_REPORT;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_REPORT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: values the outputs take in the upcoming state.
  always_comb begin
    gnt_s          = '0;
    busy_s         = 1'b0;
    result_valid_s = 1'b0;
    result_match_s = 1'b0;
    result_lane_s  = '0;
    case (next_state_s)
      ST_SHIFT: begin
        busy_s = 1'b1;
        // Load the arbiter pick on entry, then hold it for the whole frame.
        if (state_r == ST_IDLE) begin
          gnt_s = arb_gnt_s;
        end else begin
          gnt_s = gnt;
        end
      end
      ST_REPORT: begin
        busy_s         = 1'b1;
        result_valid_s = 1'b1;
        result_match_s = (frame_next_s == PATTERN);
        result_lane_s  = lane_r;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      result_lane  <= '0;
    end else begin
      gnt          <= gnt_s;
      busy         <= busy_s;
      result_valid <= result_valid_s;
      result_match <= result_match_s;
      result_lane  <= result_lane_s;
    end
  end

  // Lane latch, bit counter, frame shift register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r    <= '0;
      ptr_r     <= '0;
      bit_cnt_r <= '0;
      frame_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            lane_r    <= arb_idx_s;
            bit_cnt_r <= '0;
          end else begin
            lane_r    <= lane_r;
            bit_cnt_r <= bit_cnt_r;
          end
        end
        ST_SHIFT: begin
          frame_r   <= frame_next_s;
          bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BIT_W'(1);
        end
        ST_REPORT: begin
          // Lane just served drops to lowest priority next round.
          ptr_r <= (lane_r == LANE_W'(N_LANES - 1)) ? '0 : lane_r + LANE_W'(1);
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Per-lane saturating match counters; updated at the end of the report
  // cycle so a clear in that same cycle overrides the increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      for (int i = 0; i < N_LANES; i++) begin
        cnt_r[i] <= '0;
      end
    end else if ((state_r == ST_REPORT) && result_match &&
                 (cnt_r[lane_r] != {CNT_W{1'b1}})) begin
      cnt_r[lane_r] <= cnt_r[lane_r] + CNT_W'(1);
    end else begin
      cnt_r[lane_r] <= cnt_r[lane_r];
    end
  end

  // Counter read port, showing the value before any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (rd_in_range_s) begin
      rd_cnt <= cnt_r[rd_sel];
    end else begin
      rd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_frame_check_sched.sv
module tb_frame_check_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] gnt;
  logic       busy;
  logic       result_valid;
  logic       result_match;
  logic [1:0] result_lane;
  logic       clr_cnt;
  logic [1:0] rd_sel;
  logic [7:0] rd_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] PAT = 6'b011100;

  frame_check_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .data         (data),
    .gnt          (gnt),
    .busy         (busy),
    .result_valid (result_valid),
    .result_match (result_match),
    .result_lane  (result_lane),
    .clr_cnt      (clr_cnt),
    .rd_sel       (rd_sel),
    .rd_cnt       (rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one frame for a single requesting lane, starting in an idle cycle.
  // Returns in the report cycle with req/data cleared.
  task automatic frame(input int lane, input logic [5:0] bits, input logic exp_m,
                       input int drop_k);
    logic [3:0] oh;
    logic [5:0] sh;
    oh  = 4'b0001 << lane;
    sh  = bits;
    req = oh;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("gnt_shift", 32'(gnt), 32'(oh));
      chk("busy_shift", 32'(busy), 32'd1);
      chk("rv_shift", 32'(result_valid), 32'd0);
      if (k == drop_k) req = 4'b0000;
      data = oh & {4{sh[5]}};
      sh   = sh << 1;
      tick();
    end
    req  = 4'b0000;
    data = 4'b0000;
    chk("gnt_report", 32'(gnt), 32'd0);
    chk("rv_report", 32'(result_valid), 32'd1);
    chk("rm_report", 32'(result_match), 32'(exp_m));
    chk("rl_report", 32'(result_lane), 32'(lane));
    chk("busy_report", 32'(busy), 32'd1);
  endtask

  initial begin
    logic [3:0] oh;
    rst     = 1'b1;
    req     = 4'b0000;
    data    = 4'b0000;
    clr_cnt = 1'b0;
    rd_sel  = 2'd0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_rm", 32'(result_match), 32'd0);
    chk("rst_rl", 32'(result_lane), 32'd0);
    chk("rst_rdcnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0;

    // Single matching frame on lane 0.
    frame(0, PAT, 1'b1, -1);
    tick();
    chk("idle_rv", 32'(result_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("rd0_before", 32'(rd_cnt), 32'd0);
    tick();
    chk("rd0_after", 32'(rd_cnt), 32'd1);

    // Mismatching frame on lane 2, req dropped in the third grant cycle.
    frame(2, 6'b111000, 1'b0, 2);
    rd_sel = 2'd2;
    tick();
    chk("idle2_gnt", 32'(gnt), 32'd0);
    tick();
    chk("rd2_nomatch", 32'(rd_cnt), 32'd0);
    rd_sel = 2'd0;
    tick();
    chk("rd0_kept", 32'(rd_cnt), 32'd1);

    // Reset in the third shift cycle of a lane 2 frame.
    req = 4'b0100;
    tick();
    chk("mid_gnt1", 32'(gnt), 32'h4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rv", 32'(result_valid), 32'd0);
    rst = 1'b0;
    req = 4'b1111;

    // Round-robin with all lanes requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      tick();
      chk("rr_gnt_first", 32'(gnt), 32'(oh));
      chk("rr_rv_first", 32'(result_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("rr_gnt_hold", 32'(gnt), 32'(oh));
      end
      tick();
      chk("rr_rv", 32'(result_valid), 32'd1);
      chk("rr_rl", 32'(result_lane), 32'(i % 4));
      chk("rr_rm", 32'(result_match), 32'd0);
      chk("rr_gnt_report", 32'(gnt), 32'd0);
      if (i == 4) req = 4'b0000;
      tick();
      chk("rr_idle_gnt", 32'(gnt), 32'd0);
      chk("rr_idle_busy", 32'(busy), 32'd0);
      chk("rr_idle_rv", 32'(result_valid), 32'd0);
    end
    chk("rr_rd0_cleared", 32'(rd_cnt), 32'd0);

    // Saturation: 260 matching frames on lane 1.
    for (int n = 0; n < 260; n++) begin
      frame(1, PAT, 1'b1, -1);
      tick();
    end
    rd_sel = 2'd1;
    tick();
    chk("sat_rd1", 32'(rd_cnt), 32'd255);

    // Clear coinciding with a matching report.
    frame(1, PAT, 1'b1, -1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_rd_before", 32'(rd_cnt), 32'd255);
    tick();
    chk("clr_rd_after", 32'(rd_cnt), 32'd0);

    // Counting resumes after the clear.
    frame(1, PAT, 1'b1, -1);
    tick();
    chk("post_clr_before", 32'(rd_cnt), 32'd0);
    tick();
    chk("post_clr_after", 32'(rd_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_check_sched.md
Name: frame_check_sched

Overview:
- Shares one fixed-length serial pattern checker between N_LANES serial requesters.
- Round-robin grants one lane for exactly one FRAME_LEN-bit frame and compares the frame MSB-first against PATTERN.
- Reports match/not_match per frame and keeps saturating per-lane match counters.
- Sits between the serial lane sources and the status/CSR logic.

Parameters:
- N_LANES, 4, number of requesting serial lanes (2..8).
- FRAME_LEN, 6, bits per frame.
- PATTERN, 6'b011100, expected frame, first bit = MSB.
- CNT_W, 8, width of each per-lane match counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- req, input, N_LANES, per-lane frame request level.
- data, input, N_LANES, per-lane serial bit, sampled only for the granted lane.
- gnt, output, N_LANES, one-hot grant; high for the FRAME_LEN sampling cycles.
- busy, output, 1, high in SHIFT or REPORT.
- result_valid, output, 1, one-cycle pulse per completed frame.
- result_match, output, 1, 1 = frame equals PATTERN; valid with result_valid.
- result_lane, output, clog2(N_LANES), lane of the reported frame.
- clr_cnt, input, 1, clear all match counters.
- rd_sel, input, clog2(N_LANES), counter read select.
- rd_cnt, output, CNT_W, match count of lane rd_sel, registered.

Behaviour:
- Reset (rst sampled high at clk edge): every output is 0, state=IDLE, RR pointer=0, bit_cnt=0, all counters=0. A reset mid-frame aborts the frame with no result pulse.
- FSM states: IDLE, SHIFT, REPORT. All outputs are registered.
- IDLE:
  - If |req, pick the first requesting lane at or after the pointer, wrapping modulo N_LANES.
  - Latch the lane, go to SHIFT, and assert gnt[lane] from the next cycle.
  - If no req, stay in IDLE.
- SHIFT:
  - gnt[lane]=1.
  - Each cycle, shift data[lane] into the frame register and increment bit_cnt.
  - The first bit is sampled in the first cycle gnt is high.
  - req changes are ignored; the frame always runs the full FRAME_LEN bits, with no early abort on mismatch.
  - When bit_cnt==FRAME_LEN-1, go to REPORT.
- REPORT:
  - gnt=0, result_valid=1, result_lane=lane.
  - result_match = (frame register == PATTERN).
  - If matched, counter[lane] increments.
  - Pointer becomes (lane+1) mod N_LANES; next state is IDLE.
- Latency: req high in cycle 0 -> gnt high in cycles 1..FRAME_LEN -> result_valid in cycle FRAME_LEN+1. The earliest next grant is in cycle FRAME_LEN+3. busy is high in cycles 1..FRAME_LEN+1.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt zeroes all counters; when clr_cnt coincides with an increment, clear wins.
  - rd_cnt = counter[rd_sel] registered, 1-cycle latency, reflecting the value before any same-cycle update.
- Out-of-range rd_sel (N_LANES not a power of 2): rd_cnt=0.

Decomposition:
- Shared package: FSM state enum, default PATTERN/FRAME_LEN constants, clog2 lane-index width.
- One sub-module: rr_arbiter (req vector + pointer -> one-hot grant + index, combinational).
- Frame shift register, compare and counters stay in the top level.

Test Plan:
- Single lane: req[0] held, lane 0 drives 0,1,1,1,0,0 -> gnt=4'b0001 in cycles 1-6; cycle 7: result_valid=1, result_match=1, result_lane=0; rd_sel=0 -> rd_cnt=1.
- Mismatch: lane 2 drives 1,1,1,0,0,0 -> result_match=0, counter[2] unchanged; req[2] dropped in cycle 3 -> frame still completes with 6 grant cycles.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0, each separated by one idle cycle; no lane is granted twice before all others.
- Saturation/clear: CNT_W=8, 260 matching frames on lane 1 -> rd_cnt=255; clr_cnt in the same cycle as a REPORT match -> counter=0.
- Reset mid-frame: rst high in cycle 3 of SHIFT -> next cycle gnt=0, busy=0, no result_valid; lane 0 is granted first afterwards.
